// File: rtl/dyt_pkg.sv
// Writeback unit shared definitions.
// Widths, FIFO geometry and the result bundle carried to the register file.
package dyt_pkg;

    localparam int ADDR_WIDTH    = 4;
    localparam int XLEN          = 32;
    localparam int WB_FIFO_DEPTH = 4;
    localparam int STARVE_LIMIT  = 3;

    localparam int PTR_W   = $clog2(WB_FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int STARVE_W = 2;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    function automatic logic writes_reg(
        input logic [ADDR_WIDTH-1:0] rd
    );
        return rd != '0;
    endfunction

endpackage

// File: rtl/dyt_wb_fifo.sv
// Four-entry load-result FIFO with registered occupancy.
// Push is ignored when full and pop when empty, so callers may gate loosely.
module dyt_wb_fifo
    import dyt_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_t        din,
    output wb_entry_t        dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wb_entry_t        mem [WB_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = cnt == CNT_W'(WB_FIFO_DEPTH);
    assign empty   = cnt == '0;
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are PTR_W wide so they wrap modulo depth on their own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/dyt_writeback_unit.sv
// Writeback arbiter: ALU results versus queued load results, one write per cycle.
// A starvation counter forces the load queue through after repeated ALU wins.
module dyt_writeback_unit
    import dyt_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [XLEN-1:0]       w_data,
    input  logic [ADDR_WIDTH-1:0] r_a_addr,
    input  logic [ADDR_WIDTH-1:0] r_b_addr,
    output logic                  fwd_a_hit,
    output logic                  fwd_b_hit,
    output logic [CNT_W-1:0]      fifo_count
);

    wb_entry_t           ld_in;
    wb_entry_t           head;
    wb_entry_t           alu_in;
    wb_entry_t           sel;
    logic                fifo_full;
    logic                fifo_empty;
    logic                alu_win;
    logic                fifo_win;
    logic                win;
    logic [STARVE_W-1:0] starve;

    assign ld_in  = '{rd: ld_rd, data: ld_data};
    assign alu_in = '{rd: alu_rd, data: alu_data};

    dyt_wb_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ld_valid && ld_ready),
        .pop   (fifo_win),
        .din   (ld_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ld_ready  = !fifo_full;
    assign alu_ready = !((starve == STARVE_W'(STARVE_LIMIT)) && !fifo_empty);
    assign alu_win   = alu_valid && alu_ready;
    assign fifo_win  = !alu_win && !fifo_empty;
    assign win       = alu_win || fifo_win;
    assign sel       = alu_win ? alu_in : head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_en   <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
            starve <= '0;
        end else begin
            w_en <= win && writes_reg(sel.rd);
            if (win) begin
                w_addr <= sel.rd;
                w_data <= sel.data;
            end
            // alu_ready drops at the limit, so the counter never wraps.
            if (fifo_win || fifo_empty) begin
                starve <= '0;
            end else if (alu_win) begin
                starve <= starve + STARVE_W'(1);
            end
        end
    end

    assign fwd_a_hit = w_en && (w_addr == r_a_addr) && (r_a_addr != '0);
    assign fwd_b_hit = w_en && (w_addr == r_b_addr) && (r_b_addr != '0);

endmodule

// File: tb/tb_dyt_writeback_unit.sv
// Directed bench for dyt_writeback_unit.
// Stimulus queues expected writes; a negedge monitor checks every w_en pulse.
module tb_dyt_writeback_unit;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  ld_rd;
    logic [31:0] ld_data;
    logic        w_en;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic [3:0]  r_a_addr;
    logic [3:0]  r_b_addr;
    logic        fwd_a_hit;
    logic        fwd_b_hit;
    logic [2:0]  fifo_count;

    dyt_writeback_unit dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .w_en       (w_en),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .r_a_addr   (r_a_addr),
        .r_b_addr   (r_b_addr),
        .fwd_a_hit  (fwd_a_hit),
        .fwd_b_hit  (fwd_b_hit),
        .fifo_count (fifo_count)
    );

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [3:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && w_en) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, none expected",
                         w_addr, w_data);
            end else begin
                e = q.pop_front();
                if (w_addr !== e.a || w_data !== e.d) begin
                    fails++;
                    $display("FAIL write_order: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                             w_addr, w_data, e.a, e.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Per-cycle expectations for the fill test with x0 ALU traffic.
    logic       exp_ldr [6] = '{1, 1, 1, 1, 0, 1};
    logic       exp_alr [6] = '{1, 1, 1, 1, 0, 1};
    logic [2:0] exp_cnt [6] = '{0, 1, 2, 3, 4, 3};

    initial begin
        int   idx;
        logic took;
        rst = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        r_a_addr = 0; r_b_addr = 0;
        idle(2);
        #1;
        check("reset_w_en", 32'(w_en), 0);
        check("reset_w_addr", 32'(w_addr), 0);
        check("reset_w_data", w_data, 0);
        check("reset_count", 32'(fifo_count), 0);
        check("reset_ld_ready", 32'(ld_ready), 1);
        check("reset_alu_ready", 32'(alu_ready), 1);
        rst = 1'b1;
        idle(1);

        // ALU only, latency 1
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        expect_wr(5, 32'hDEADBEEF);
        check("alu_ready_idle", 32'(alu_ready), 1);
        step();
        alu_valid = 0;
        check("alu_w_en", 32'(w_en), 1);
        check("alu_w_addr", 32'(w_addr), 5);
        check("alu_w_data", w_data, 32'hDEADBEEF);
        step();
        check("alu_w_en_after", 32'(w_en), 0);

        // x0 load: consumed, never written
        ld_valid = 1; ld_rd = 0; ld_data = 32'h1234;
        step();
        ld_valid = 0;
        check("x0_count_pushed", 32'(fifo_count), 1);
        step();
        check("x0_count_popped", 32'(fifo_count), 0);
        check("x0_w_en", 32'(w_en), 0);
        step();
        check("x0_w_en_later", 32'(w_en), 0);

        // Starvation: one queued load, ALU held valid
        ld_valid = 1; ld_rd = 3; ld_data = 32'hA1;
        step();
        ld_valid = 0;
        check("starve_count", 32'(fifo_count), 1);
        expect_wr(9, 32'h11);
        expect_wr(9, 32'h12);
        expect_wr(9, 32'h13);
        expect_wr(3, 32'hA1);
        expect_wr(9, 32'h14);
        alu_valid = 1; alu_rd = 9;
        for (int i = 0; i < 3; i++) begin
            alu_data = 32'h11 + 32'(i);
            check($sformatf("starve_ready_%0d", i), 32'(alu_ready), 1);
            step();
        end
        alu_data = 32'h14;
        check("starve_blocked", 32'(alu_ready), 0);
        step();
        check("starve_released", 32'(alu_ready), 1);
        check("starve_drained", 32'(fifo_count), 0);
        step();
        alu_valid = 0;
        idle(2);

        // Fill to full behind x0 ALU traffic, then drain 5 loads in order
        for (int i = 1; i <= 5; i++) expect_wr(4'(i), 32'(i));
        idx = 1;
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
        for (int c = 0; c < 6; c++) begin
            ld_valid = idx <= 5;
            ld_rd = 4'(idx);
            ld_data = 32'(idx);
            check($sformatf("fill_ld_ready_%0d", c), 32'(ld_ready), 32'(exp_ldr[c]));
            check($sformatf("fill_alu_ready_%0d", c), 32'(alu_ready), 32'(exp_alr[c]));
            check($sformatf("fill_count_%0d", c), 32'(fifo_count), 32'(exp_cnt[c]));
            took = ld_valid && ld_ready;
            step();
            if (took) idx++;
        end
        alu_valid = 0; ld_valid = 0;
        check("fill_all_pushed", 32'(idx), 6);
        idle(6);
        check("fill_drained", 32'(fifo_count), 0);

        // Forwarding snoop
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        expect_wr(7, 32'h77);
        step();
        alu_valid = 0;
        r_a_addr = 7; r_b_addr = 0;
        #1;
        check("fwd_a_hit", 32'(fwd_a_hit), 1);
        check("fwd_b_x0", 32'(fwd_b_hit), 0);
        r_b_addr = 7; r_a_addr = 3;
        #1;
        check("fwd_b_hit", 32'(fwd_b_hit), 1);
        check("fwd_a_miss", 32'(fwd_a_hit), 0);
        step();
        r_a_addr = 7;
        #1;
        check("fwd_a_idle", 32'(fwd_a_hit), 0);
        r_a_addr = 0; r_b_addr = 0;

        // Reset mid-burst: 3 queued loads and a pending ALU write are dropped
        alu_valid = 1; alu_rd = 0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1; ld_rd = 4'(10 + i); ld_data = 32'hB0 + 32'(i);
            if (i == 2) begin
                alu_rd = 6; alu_data = 32'h66;
            end
            step();
        end
        check("mid_count", 32'(fifo_count), 3);
        check("mid_pending", 32'(w_en), 1);
        rst = 1'b0;
        alu_valid = 0; ld_valid = 0; alu_rd = 0;
        #1;
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_w_en", 32'(w_en), 0);
        idle(2);
        rst = 1'b1;
        idle(8);
        check("post_rst_count", 32'(fifo_count), 0);
        check("post_rst_w_en", 32'(w_en), 0);
        check("post_rst_ld_ready", 32'(ld_ready), 1);

        check("scoreboard_empty", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
